// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencing (BOOT/RUN/STALL/HALTED/TRAP).
// Picks the next PC from sequential, branch, jump and register-jump targets.
// The optional target trap checker is enabled by defining the FETCH_TRAP_EN macro.
// When the macro is not defined, TRAP cannot be reached and Trap/TrapAddr are tied to zero.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 256
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        Resume,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] ImemRdAddr,
    output logic [31:0] PcPlus4,
    output logic        FetchValid,
    output logic [2:0]  FetchState,
    output logic        Trap,
    output logic [31:0] TrapAddr
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STALL  = 3'd2,
        ST_HALTED = 3'd3,
        ST_TRAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        target_bad;

    assign pc_plus4   = pc_q + 32'd4;
    assign ImemRdAddr = pc_q;
    assign PcPlus4    = pc_plus4;
    assign FetchState = state_q;

    // Redirect priority: register jump, then absolute jump, then branch, then sequential
    always_comb begin
        target = pc_plus4;
        if (JumpReg)
            target = RegTarget;
        else if (Jump)
            target = {pc_plus4[31:28], JumpIndex, 2'b00};
        else if (BranchTaken)
            target = pc_plus4 + {BranchOffset[29:0], 2'b00};
    end

`ifdef FETCH_TRAP_EN
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    assign target_bad = (target[1:0] != 2'b00) || ({1'b0, target} >= IMEM_BYTES);
    assign Trap       = trap_q;
    assign TrapAddr   = trap_addr_q;
`else
    assign target_bad = 1'b0;
    assign Trap       = 1'b0;
    assign TrapAddr   = 32'h0000_0000;
`endif

    // Next-state, next-PC and fetch-valid decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        FetchValid = 1'b0;
`ifdef FETCH_TRAP_EN
        trap_d      = trap_q;
        trap_addr_d = trap_addr_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                FetchValid = 1'b1;
                if (Halt) begin
                    state_d = ST_HALTED;
                end else if (Stall) begin
                    state_d = ST_STALL;
                end else if (target_bad) begin
                    state_d = ST_TRAP;
`ifdef FETCH_TRAP_EN
                    trap_d      = 1'b1;
                    trap_addr_d = target;
`endif
                end else begin
                    state_d = ST_RUN;
                    pc_d    = target;
                end
            end
            ST_HALTED: begin
                if (Resume && !Halt)
                    state_d = ST_RUN;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and trap registers with asynchronous reset
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
`ifdef FETCH_TRAP_EN
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0000_0000;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef FETCH_TRAP_EN
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks of pc_fetch_unit against a behavioural model.
// Honours FETCH_TRAP_EN so the same bench works with either build of the design.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int MB_BOOT = 0, MB_RUN = 1, MB_STALL = 2, MB_HALT = 3, MB_TRAP = 4;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        Stall, Halt, Resume, BranchTaken, Jump, JumpReg;
    logic [31:0] BranchOffset, RegTarget;
    logic [25:0] JumpIndex;
    logic [31:0] ImemRdAddr, PcPlus4, TrapAddr;
    logic        FetchValid, Trap;
    logic [2:0]  FetchState;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    int          m_state;
    logic [31:0] m_pc;
    logic        m_trap;
    logic [31:0] m_taddr;

    pc_fetch_unit #(.RESET_VECTOR(RV), .IMEM_WORDS(256)) dut (
        .CLK(CLK), .RST_n(RST_n), .Stall(Stall), .Halt(Halt), .Resume(Resume),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .Jump(Jump),
        .JumpIndex(JumpIndex), .JumpReg(JumpReg), .RegTarget(RegTarget),
        .ImemRdAddr(ImemRdAddr), .PcPlus4(PcPlus4), .FetchValid(FetchValid),
        .FetchState(FetchState), .Trap(Trap), .TrapAddr(TrapAddr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = MB_BOOT;
        m_pc    = RV;
        m_trap  = 1'b0;
        m_taddr = 32'h0;
    endtask

    // Advance the model by one rising edge using the present inputs
    task automatic model_next();
        logic [31:0] nxt, tgt;
        logic bad;
        nxt = m_pc + 32'd4;
        if (JumpReg)          tgt = RegTarget;
        else if (Jump)        tgt = (nxt & 32'hF000_0000) | (32'(JumpIndex) * 32'd4);
        else if (BranchTaken) tgt = nxt + BranchOffset * 32'd4;
        else                  tgt = nxt;
`ifdef FETCH_TRAP_EN
        bad = (tgt % 4 != 0) || (tgt >= 32'd1024);
`else
        bad = 1'b0;
`endif
        case (m_state)
            MB_BOOT: m_state = MB_RUN;
            MB_RUN, MB_STALL: begin
                if (Halt)       m_state = MB_HALT;
                else if (Stall) m_state = MB_STALL;
                else if (bad) begin
                    m_state = MB_TRAP; m_trap = 1'b1; m_taddr = tgt;
                end else begin
                    m_state = MB_RUN;  m_pc = tgt;
                end
            end
            MB_HALT: if (Resume && !Halt) m_state = MB_RUN;
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  ImemRdAddr, m_pc);
        chk({tag, ".pc4"},   PcPlus4, m_pc + 32'd4);
        chk({tag, ".valid"}, {31'b0, FetchValid},
            (m_state == MB_RUN || m_state == MB_STALL) ? 32'd1 : 32'd0);
        chk({tag, ".state"}, {29'b0, FetchState}, 32'(m_state));
        chk({tag, ".trap"},  {31'b0, Trap}, {31'b0, m_trap});
        chk({tag, ".taddr"}, TrapAddr, m_taddr);
        $display("%s: addr=%h state=%0d valid=%b trap=%b", tag, ImemRdAddr, FetchState, FetchValid, Trap);
    endtask

    task automatic step(input string tag);
        model_next();
        @(posedge CLK);
        #1;
        check_all(tag);
        @(negedge CLK);
    endtask

    // Pulse reset low mid-cycle (between edges) and check it acts immediately
    task automatic mid_reset(input string tag);
        #2 RST_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        chk({tag, ".rv"}, ImemRdAddr, RV);
        #1 RST_n = 1'b1;
    endtask

    task automatic clear_in();
        Stall = 0; Halt = 0; Resume = 0; BranchTaken = 0; Jump = 0; JumpReg = 0;
        BranchOffset = 0; RegTarget = 0; JumpIndex = 0;
    endtask

    task automatic go_to(input logic [31:0] pc, input string tag);
        clear_in();
        JumpReg = 1; RegTarget = pc;
        step(tag);
        clear_in();
    endtask

    initial begin
        clear_in();
        RST_n = 1'b0;
        model_reset();
        #1 check_all("reset");
        @(negedge CLK);
        RST_n = 1'b1;
        check_all("boot");

        // Free-running after reset: 0 (BOOT), 0, 4, 8
        step("run0"); chk("run0.k", ImemRdAddr, 32'h0);
        step("run1"); chk("run1.k", ImemRdAddr, 32'h4);
        step("run2"); chk("run2.k", ImemRdAddr, 32'h8);

        // Backward branch, then jump beating branch
        go_to(32'h10, "to10");
        BranchTaken = 1; BranchOffset = 32'hFFFF_FFFE;
        step("branch"); chk("branch.k", ImemRdAddr, 32'h0C);
        go_to(32'h10, "to10b");
        BranchTaken = 1; BranchOffset = 32'hFFFF_FFFE; Jump = 1; JumpIndex = 26'h40;
        step("jumpwin"); chk("jumpwin.k", ImemRdAddr, 32'h100);

        // Stall holds PC and ignores redirects
        go_to(32'h20, "to20");
        Stall = 1; BranchTaken = 1; BranchOffset = 32'd5;
        step("stall0"); chk("stall0.k", ImemRdAddr, 32'h20);
        step("stall1"); chk("stall1.k", ImemRdAddr, 32'h20);
        Stall = 0; BranchOffset = 32'd4;
        step("unstall"); chk("unstall.k", ImemRdAddr, 32'h34);

        // Halt, hold with redirects ignored, Halt+Resume stays halted, then resume
        go_to(32'h40, "to40");
        Halt = 1;
        step("halt");
        Halt = 0; JumpReg = 1; RegTarget = 32'h80;
        for (int i = 0; i < 5; i++) step($sformatf("halted%0d", i));
        clear_in(); Halt = 1; Resume = 1;
        step("haltres");
        Halt = 0;
        step("resume"); chk("resume.k", ImemRdAddr, 32'h40);
        Resume = 0;
        step("after"); chk("after.k", ImemRdAddr, 32'h44);

`ifndef FETCH_TRAP_EN
        // Sequential wrap at top of address space
        go_to(32'hFFFF_FFFC, "totop");
        step("wrap"); chk("wrap.k", ImemRdAddr, 32'h0);
`endif
        Halt = 1;
        step("halt2");
        Halt = 0;
        mid_reset("rst_halted");
        step("boot2");

        // Misaligned, out-of-range register target
        JumpReg = 1; RegTarget = 32'h402;
        step("jr402");
`ifdef FETCH_TRAP_EN
        chk("jr402.trap", {31'b0, Trap}, 32'd1);
        chk("jr402.taddr", TrapAddr, 32'h402);
`else
        chk("jr402.pc", ImemRdAddr, 32'h402);
`endif
        clear_in();
        mid_reset("rst_after402");

        // Random traffic with occasional mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            Halt        = ($urandom_range(0, 9) == 0);
            Resume      = ($urandom_range(0, 2) == 0);
            Stall       = ($urandom_range(0, 3) == 0);
            JumpReg     = ($urandom_range(0, 7) == 0);
            Jump        = ($urandom_range(0, 7) == 0);
            BranchTaken = ($urandom_range(0, 3) == 0);
            BranchOffset = 32'($urandom_range(0, 64)) - 32'd32;
            JumpIndex   = 26'($urandom_range(0, 255));
            RegTarget   = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h3FC);
            if ($urandom_range(0, 99) == 0)
                mid_reset($sformatf("rrst%0d", n));
            step($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
